// File: rtl/mm_pkg.sv
// Shared types and defaults for the mm feed controller: FSM state encoding,
// default array geometry and the packed-vector width helper.
package mm_pkg;

  localparam int ELEMENT_WIDTH_DEF = 16;
  localparam int ELEMENT_COUNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_t;

  function automatic int full_width(input int elem_width, input int elem_count);
    return elem_width * elem_count;
  endfunction

endpackage

// File: rtl/mm_feed_ctrl_if.sv
// Command, tile-buffer read and skew-loader feed signals of mm_feed_ctrl.
// master = command/buffer side, slave = the feed controller.
interface mm_feed_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10,
  parameter int FULL_WIDTH = mm_pkg::full_width(mm_pkg::ELEMENT_WIDTH_DEF,
                                                mm_pkg::ELEMENT_COUNT_DEF)
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  len;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [FULL_WIDTH-1:0] rd_data;
  logic [FULL_WIDTH-1:0] feed_data;
  logic                  feed_valid;
  logic                  feed_last;

  modport master (
    output start, abort, base_addr, len, rd_data,
    input  busy, done, rd_en, rd_addr, feed_data, feed_valid, feed_last
  );

  modport slave (
    input  start, abort, base_addr, len, rd_data,
    output busy, done, rd_en, rd_addr, feed_data, feed_valid, feed_last
  );
endinterface

// File: rtl/mm_addr_gen.sv
// Tile-buffer address generator: loads base/count, steps one address per
// issued read with natural wrap, and flags the cycle issuing the final read.
module mm_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_remain <= i_len;
    end else if (i_advance) begin
      r_addr   <= r_addr + ADDR_WIDTH'(1);
      r_remain <= r_remain - LEN_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remain == LEN_WIDTH'(1));

endmodule

// File: rtl/mm_feed_ctrl.sv
// Feeds one operand tile pass from the tile buffer into the skew loader,
// then flushes with zero vectors. Optional perf counter: MM_FEED_CTRL_PERF_EN.
module mm_feed_ctrl
  import mm_pkg::*;
#(
  parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
  parameter int ELEMENT_COUNT = ELEMENT_COUNT_DEF,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  mm_feed_ctrl_if.slave bus
`ifdef MM_FEED_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int FULL_WIDTH = full_width(ELEMENT_WIDTH, ELEMENT_COUNT);
  localparam int DRAIN_W    = $clog2(ELEMENT_COUNT + 1);

  feed_state_t           r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_en;
  logic [DRAIN_W-1:0]    r_drain_cnt;
  logic                  r_rd_pipe;
  logic                  r_last_pipe;
  logic                  r_feed_valid;
  logic                  r_feed_last;
  logic [FULL_WIDTH-1:0] r_feed_data;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_kill;
  logic                  w_issue_last;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  assign w_accept = (r_state == ST_IDLE) && bus.start && !bus.abort;
  assign w_load   = w_accept && (bus.len != '0);
  assign w_kill   = (r_state != ST_IDLE) && bus.abort;

  mm_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_base    (bus.base_addr),
    .i_len     (bus.len),
    .i_advance (r_rd_en),
    .o_addr    (w_rd_addr),
    .o_last    (w_issue_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_drain_cnt <= '0;
    end else if (w_kill) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_load) begin
              r_state <= ST_FEED;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_FEED: begin
          if (w_issue_last) begin
            r_state     <= ST_DRAIN;
            r_rd_en     <= 1'b0;
            r_drain_cnt <= '0;
          end
        end
        // Two cycles let the last read reach feed_data, the rest flush the skew.
        ST_DRAIN: begin
          if (r_drain_cnt == DRAIN_W'(ELEMENT_COUNT)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe    <= 1'b0;
      r_last_pipe  <= 1'b0;
      r_feed_valid <= 1'b0;
      r_feed_last  <= 1'b0;
      r_feed_data  <= '0;
    end else if (w_kill) begin
      r_rd_pipe    <= 1'b0;
      r_last_pipe  <= 1'b0;
      r_feed_valid <= 1'b0;
      r_feed_last  <= 1'b0;
      r_feed_data  <= '0;
    end else begin
      r_rd_pipe    <= r_rd_en;
      r_last_pipe  <= r_rd_en && w_issue_last;
      r_feed_valid <= r_rd_pipe;
      r_feed_last  <= r_last_pipe;
      r_feed_data  <= r_rd_pipe ? bus.rd_data : '0;
    end
  end

`ifdef MM_FEED_CTRL_PERF_EN
  logic [31:0] r_perf_acc;
  logic [31:0] r_perf_cycles;

  // The accepting cycle counts as 1; the DONE cycle is added when publishing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_acc    <= '0;
      r_perf_cycles <= '0;
    end else if (w_kill) begin
      r_perf_acc <= '0;
    end else if (w_accept) begin
      r_perf_acc <= 32'd1;
    end else if (r_state == ST_DONE) begin
      r_perf_cycles <= r_perf_acc + 32'd1;
    end else if (r_state != ST_IDLE) begin
      r_perf_acc <= r_perf_acc + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = w_rd_addr;
  assign bus.feed_data  = r_feed_data;
  assign bus.feed_valid = r_feed_valid;
  assign bus.feed_last  = r_feed_last;

endmodule

// File: tb/tb_mm_feed_ctrl.sv
// Directed bench for mm_feed_ctrl: normal passes, len=0, address wrap, abort,
// ignored restart, async reset mid-pass and (when enabled) the perf counter.
module tb_mm_feed_ctrl;

  localparam int AW = 10;
  localparam int LW = 10;
  localparam int FW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  mm_feed_ctrl_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FULL_WIDTH(FW)) bus ();

`ifdef MM_FEED_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mm_feed_ctrl #(
    .ELEMENT_WIDTH (16),
    .ELEMENT_COUNT (4),
    .ADDR_WIDTH    (AW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MM_FEED_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  function automatic logic [FW-1:0] tag(input logic [AW-1:0] a);
    return {6'h28, a, 6'h2C, a, 6'h30, a, 6'h34, a};
  endfunction

  // One-cycle-latency tile buffer; all-ones when not read so zero-forcing is visible.
  always @(posedge clk) begin
    bus.rd_data <= bus.rd_en ? tag(bus.rd_addr) : {FW{1'b1}};
  end

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string t);
    chk({t, ".busy"}, 64'(bus.busy), 64'd0);
    chk({t, ".done"}, 64'(bus.done), 64'd0);
    chk({t, ".rd_en"}, 64'(bus.rd_en), 64'd0);
    chk({t, ".feed_valid"}, 64'(bus.feed_valid), 64'd0);
    chk({t, ".feed_last"}, 64'(bus.feed_last), 64'd0);
    chk({t, ".feed_data"}, bus.feed_data, 64'd0);
  endtask

  // Cycle k counts from the first cycle after start is sampled.
  task automatic run_pass(input logic [AW-1:0] base, input int len);
    logic [AW-1:0] e_addr;
    logic [AW-1:0] d_addr;
    logic          e_rden, e_fv, e_last, e_done, e_busy;
    int            miss0;
    miss0 = n_miss;
    bus.base_addr = base;
    bus.len       = LW'(len);
    bus.start     = 1'b1;
    for (int k = 1; k <= len + 8; k++) begin
      step();
      bus.start = 1'b0;
      e_rden = (k <= len);
      e_addr = base + AW'(k - 1);
      e_fv   = (len > 0) && (k >= 3) && (k <= len + 2);
      d_addr = base + AW'(k - 3);
      e_last = (len > 0) && (k == len + 2);
      e_done = (len == 0) ? (k == 1) : (k == len + 6);
      e_busy = (len == 0) ? (k == 1) : (k <= len + 6);
      chk($sformatf("c%0d.rd_en", k), 64'(bus.rd_en), 64'(e_rden));
      if (e_rden) chk($sformatf("c%0d.rd_addr", k), 64'(bus.rd_addr), 64'(e_addr));
      chk($sformatf("c%0d.feed_valid", k), 64'(bus.feed_valid), 64'(e_fv));
      chk($sformatf("c%0d.feed_data", k), bus.feed_data, e_fv ? tag(d_addr) : 64'd0);
      chk($sformatf("c%0d.feed_last", k), 64'(bus.feed_last), 64'(e_last));
      chk($sformatf("c%0d.done", k), 64'(bus.done), 64'(e_done));
      chk($sformatf("c%0d.busy", k), 64'(bus.busy), 64'(e_busy));
    end
    $display("pass base=%03h len=%0d : %0d miscompares", base, len, n_miss - miss0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;

    repeat (3) step();
    chk_quiet("reset");
    chk("reset.rd_addr", 64'(bus.rd_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("reset released");

    run_pass(10'h010, 3);
`ifdef MM_FEED_CTRL_PERF_EN
    chk("perf.len3", 64'(perf_cycles), 64'd10);
    repeat (3) step();
    chk("perf.len3.hold", 64'(perf_cycles), 64'd10);
`endif

    run_pass(10'h000, 0);
`ifdef MM_FEED_CTRL_PERF_EN
    chk("perf.len0", 64'(perf_cycles), 64'd2);
`endif

    run_pass(10'h3FE, 4);
`ifdef MM_FEED_CTRL_PERF_EN
    chk("perf.len4", 64'(perf_cycles), 64'd11);
`endif

    // start and abort together in IDLE: nothing starts
    bus.base_addr = 10'h020;
    bus.len       = 10'd2;
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_quiet("startabort.c1");
    step();
    chk_quiet("startabort.c2");
    $display("start+abort in IDLE");

    // abort on the 2nd FEED cycle of len=8
    bus.base_addr = 10'h100;
    bus.len       = 10'd8;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("abort.c1.rd_en", 64'(bus.rd_en), 64'd1);
    step();
    chk("abort.c2.rd_addr", 64'(bus.rd_addr), 64'h101);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_quiet("abort.c3");
    for (int k = 4; k < 14; k++) begin
      step();
      chk($sformatf("abort.c%0d.done", k), 64'(bus.done), 64'd0);
      chk($sformatf("abort.c%0d.feed_valid", k), 64'(bus.feed_valid), 64'd0);
    end
`ifdef MM_FEED_CTRL_PERF_EN
    chk("perf.abort.unchanged", 64'(perf_cycles), 64'd11);
`endif
    $display("abort len=8 at 2nd FEED cycle");

    // restart while busy is ignored; async reset in DRAIN
    bus.base_addr = 10'h040;
    bus.len       = 10'd5;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.base_addr = 10'h200;
    bus.len       = 10'd2;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart.c4.rd_addr", 64'(bus.rd_addr), 64'h043);
    step();
    chk("restart.c5.rd_addr", 64'(bus.rd_addr), 64'h044);
    step();
    chk("restart.c6.rd_en", 64'(bus.rd_en), 64'd0);
    step();
    chk("restart.c7.feed_last", 64'(bus.feed_last), 64'd1);
    chk("restart.c7.feed_data", bus.feed_data, tag(10'h044));
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
`ifdef MM_FEED_CTRL_PERF_EN
    chk("perf.reset", 64'(perf_cycles), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_quiet("postreset.c1");
    step();
    chk_quiet("postreset.c2");
    $display("restart ignored, reset mid-DRAIN");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
